// File: rtl/audio_in_tone_detector_pkg.sv
// audio_pkg: note encoding, period windows and sample defaults shared by the tone generator and detector
package audio_pkg;
  typedef enum logic [1:0] {NOTE_NONE, NOTE_C4, NOTE_D5, NOTE_E5} note_t;
  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_PROC} fetch_t;
  typedef enum logic [1:0] {SCH_UNK, SCH_HI, SCH_LO} schmitt_t;
  localparam int SAMPLE_W_DEF = 32;
  localparam int AUDIO_FS = 48000;
  // inclusive period windows, in samples at AUDIO_FS
  localparam int unsigned C4_MIN = 176;
  localparam int unsigned C4_MAX = 190;
  localparam int unsigned D5_MIN = 79;
  localparam int unsigned D5_MAX = 85;
  localparam int unsigned E5_MIN = 70;
  localparam int unsigned E5_MAX = 76;
endpackage

// File: rtl/audio_in_tone_detector_if.sv
// audio_in_tone_detector_if: ADC sample pop handshake between Audio_Controller and a reader
interface audio_in_tone_detector_if #(parameter int SAMPLE_W = audio_pkg::SAMPLE_W_DEF);
  logic audio_in_available;
  logic [SAMPLE_W-1:0] left_channel_audio_in;
  logic read_audio_in;
  modport master(output audio_in_available, left_channel_audio_in, input read_audio_in);
  modport slave(input audio_in_available, left_channel_audio_in, output read_audio_in);
endinterface

// File: rtl/audio_in_tone_detector_note_classifier.sv
// note_classifier: period-to-note lookup, loaded only when two consecutive periods agree
module note_classifier
  import audio_pkg::*;
#(
  parameter int PER_W = 12
)(
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             i_valid,
  input  logic             i_clear,
  input  logic [PER_W-1:0] i_period,
  output note_t            o_note
);
  logic [31:0] w_p;
  note_t w_cls, r_last;
  always_comb begin
    w_p = 32'(i_period);
    w_cls = (w_p >= C4_MIN && w_p <= C4_MAX) ? NOTE_C4 :
            (w_p >= D5_MIN && w_p <= D5_MAX) ? NOTE_D5 :
            (w_p >= E5_MIN && w_p <= E5_MAX) ? NOTE_E5 : NOTE_NONE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || i_clear) begin
      r_last <= NOTE_NONE;
      o_note <= NOTE_NONE;
    end else if (i_valid) begin
      r_last <= w_cls;
      if (w_cls == r_last) o_note <= w_cls;
    end
  end
endmodule

// File: rtl/audio_in_tone_detector.sv
// audio_in_tone_detector: pops ADC samples, measures period/peak between rising Schmitt crossings
// and reports a debounced note for game logic.
module audio_in_tone_detector
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int HYST       = 2000000,
  parameter int PER_W      = 12,
  parameter int MAX_PERIOD = 4095
)(
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  audio_in_tone_detector_if.slave aud,
  output logic [PER_W-1:0]      period,
  output logic [SAMPLE_W-2:0]   amplitude,
  output logic                  period_valid,
  output logic                  tone_present,
  output logic [1:0]            note_id
);
  localparam logic signed [SAMPLE_W-1:0] L_HI = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] L_LO = -L_HI;
  localparam logic [PER_W-1:0] L_MAX = PER_W'(MAX_PERIOD);
  fetch_t r_fsm, w_fsm_nxt;
  schmitt_t r_sch, w_sch_nxt;
  note_t w_note;
  logic signed [SAMPLE_W-1:0] r_samp;
  logic [SAMPLE_W-1:0] w_neg;
  logic [SAMPLE_W-2:0] r_peak, w_abs, w_peak_nxt;
  logic [PER_W-1:0] r_cnt, w_cnt_inc;
  logic r_armed, w_proc, w_rise, w_meas, w_silence;
  always_ff @(posedge CLOCK_50) r_fsm <= !resetn ? F_IDLE : w_fsm_nxt;
  always_comb begin
    w_fsm_nxt = r_fsm == F_IDLE  ? (aud.audio_in_available ? F_FETCH : F_IDLE) :
                r_fsm == F_FETCH ? F_PROC : F_IDLE;
    aud.read_audio_in = r_fsm == F_FETCH;
  end
  // counter only runs once armed; the sample that would saturate it declares silence unless it is a crossing
  always_comb begin
    w_proc = r_fsm == F_PROC;
    w_sch_nxt = r_samp >= L_HI ? SCH_HI : r_samp <= L_LO ? SCH_LO : r_sch;
    w_rise = w_proc && r_sch == SCH_LO && w_sch_nxt == SCH_HI;
    w_meas = w_rise && r_armed;
    w_cnt_inc = r_cnt == L_MAX ? L_MAX : r_cnt + 1'b1;
    w_silence = w_proc && !w_rise && r_armed && w_cnt_inc == L_MAX;
    w_neg = -r_samp;
    w_abs = !r_samp[SAMPLE_W-1] ? r_samp[SAMPLE_W-2:0] :
            r_samp[SAMPLE_W-2:0] == '0 ? {(SAMPLE_W-1){1'b1}} : w_neg[SAMPLE_W-2:0];
    w_peak_nxt = w_abs > r_peak ? w_abs : r_peak;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_samp <= '0;
      r_sch <= SCH_UNK;
      r_peak <= '0;
      r_cnt <= '0;
      r_armed <= 1'b0;
      period <= '0;
      amplitude <= '0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
    end else begin
      period_valid <= w_meas;
      if (r_fsm == F_FETCH) r_samp <= aud.left_channel_audio_in;
      if (w_proc) begin
        r_sch <= w_silence ? SCH_UNK : w_sch_nxt;
        r_peak <= (w_rise || w_silence) ? '0 : w_peak_nxt;
        r_cnt <= (w_rise || w_silence || !r_armed) ? '0 : w_cnt_inc;
        r_armed <= w_rise || (r_armed && !w_silence);
      end
      if (w_meas) begin
        period <= w_cnt_inc;
        amplitude <= w_peak_nxt;
        tone_present <= 1'b1;
      end else if (w_silence) begin
        period <= '0;
        amplitude <= '0;
        tone_present <= 1'b0;
      end
    end
  end
  note_classifier #(.PER_W(PER_W)) u_cls (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .i_valid(w_meas),
    .i_clear(w_silence),
    .i_period(w_cnt_inc),
    .o_note(w_note)
  );
  assign note_id = w_note;
endmodule

// File: tb/tb_audio_in_tone_detector.sv
// tb_audio_in_tone_detector: randomized sample stream checked each cycle against a sample-list model
module tb_audio_in_tone_detector;
  localparam longint HYST = 2000000;
  localparam int MAXP = 4095;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [11:0] period;
  logic [30:0] amplitude;
  logic period_valid, tone_present;
  logic [1:0] note_id;
  audio_in_tone_detector_if #(.SAMPLE_W(32)) aud();
  audio_in_tone_detector #(.SAMPLE_W(32), .HYST(2000000), .PER_W(12), .MAX_PERIOD(4095)) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .aud(aud),
    .period(period),
    .amplitude(amplitude),
    .period_valid(period_valid),
    .tone_present(tone_present),
    .note_id(note_id)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask
  // model: level 0=unknown 1=high 2=low; since holds |sample| of every sample after the last rising crossing
  int lvl = 0, exp_tone = 0, exp_note = 0, prev_cls = -1;
  bit armed = 0, exp_pv = 0;
  longint since[$];
  longint exp_period = 0, exp_amp = 0;
  function automatic int cls(input longint p);
    return (p >= 176 && p <= 190) ? 1 : (p >= 79 && p <= 85) ? 2 : (p >= 70 && p <= 76) ? 3 : 0;
  endfunction
  task automatic model_reset();
    lvl = 0; armed = 0; since.delete(); exp_period = 0; exp_amp = 0;
    exp_tone = 0; exp_note = 0; prev_cls = -1;
  endtask
  task automatic model_step(input longint s);
    longint a, m;
    int nl, c;
    a = (s == -64'sd2147483648) ? 64'sd2147483647 : (s < 0 ? -s : s);
    nl = s >= HYST ? 1 : (s <= -HYST ? 2 : lvl);
    if (lvl == 2 && nl == 1) begin
      if (armed) begin
        since.push_back(a);
        m = 0;
        foreach (since[i]) if (since[i] > m) m = since[i];
        exp_period = since.size(); exp_amp = m; exp_tone = 1; exp_pv = 1;
        c = cls(exp_period);
        if (c == prev_cls) exp_note = c;
        prev_cls = c;
      end
      since.delete(); armed = 1; lvl = 1;
    end else if (armed) begin
      since.push_back(a);
      if (since.size() == MAXP) begin
        exp_period = 0; exp_amp = 0; exp_tone = 0; exp_note = 0; prev_cls = -1;
        armed = 0; since.delete(); lvl = 0;
      end else lvl = nl;
    end else lvl = nl;
  endtask
  bit rst_q = 0, pend = 0, prev_read = 0, note_watch = 0;
  int pend_age = 0, pv_cnt = 0, pv82 = 0, note_slip = 0;
  longint pend_s;
  always @(posedge clk) rst_q <= resetn;
  always @(negedge clk) begin
    exp_pv = 0;
    if (!rst_q) begin
      model_reset();
      pend = 0;
      chk("read_in_reset", aud.read_audio_in, 0);
    end else if (pend) begin
      pend_age++;
      if (pend_age == 2) begin
        model_step(pend_s);
        pend = 0;
      end
    end
    chk("period", period, exp_period);
    chk("amplitude", amplitude, exp_amp);
    chk("period_valid", period_valid, exp_pv);
    chk("tone_present", tone_present, exp_tone);
    chk("note_id", note_id, exp_note);
    if (aud.read_audio_in) begin
      chk("read_back2back", prev_read, 0);
      chk("read_no_avail", aud.audio_in_available, 1);
    end
    if (aud.read_audio_in && rst_q) begin
      pend = 1; pend_age = 0;
      pend_s = longint'($signed(aud.left_channel_audio_in));
    end
    if (period_valid) pv_cnt++;
    if (period_valid && period == 12'd82) pv82++;
    if (note_watch && note_id != 2'd3) note_slip++;
    prev_read = aud.read_audio_in;
  end
  int last_wait;
  task automatic send(input longint s, input int gap);
    int w;
    aud.audio_in_available = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    aud.audio_in_available = 1'b1;
    aud.left_channel_audio_in = s[31:0];
    w = 0;
    do begin @(negedge clk); w++; end while (!aud.read_audio_in && w < 12);
    chk("pop_seen", aud.read_audio_in, 1);
    last_wait = w;
    @(posedge clk); #1;
    aud.audio_in_available = 1'b0;
  endtask
  function automatic longint ramp();
    return longint'($urandom_range(32'd2000000, 32'd1073741824));
  endfunction
  function automatic longint noise();
    return longint'($urandom_range(32'd0, 32'd3000000)) - 64'sd1500000;
  endfunction
  task automatic tone(input int p, input int n, input longint amp, input int gap_max);
    longint v;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        v = amp != 0 ? amp : ramp();
        send(i < (p + 1) / 2 ? v : -v, $urandom_range(0, gap_max));
      end
  endtask
  task automatic settle();
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int b0, w;
    int per[4];
    aud.audio_in_available = 1'b0;
    aud.left_channel_audio_in = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_amp", amplitude, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_tone", tone_present, 0);
    chk("rst_note", note_id, 0);
    chk("rst_read", aud.read_audio_in, 0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(noise(), 0);
      if (i > 0) chk("hs_interval", last_wait, 3);
    end
    tone(183, 3, 10000000, 1);
    settle();
    chk("c4_period", period, 183);
    chk("c4_amp", amplitude, 10000000);
    chk("c4_tone", tone_present, 1);
    chk("c4_note_first", note_id, 0);
    tone(183, 1, 10000000, 1);
    settle();
    chk("c4_note", note_id, 1);
    tone(73, 4, 0, 2);
    settle();
    chk("e5_note", note_id, 3);
    chk("e5_period", period, 73);
    b0 = pv82;
    note_watch = 1;
    tone(82, 1, 0, 1);
    tone(73, 3, 0, 1);
    settle();
    note_watch = 0;
    chk("outlier_82_once", pv82 - b0, 1);
    chk("outlier_note_hold", note_slip, 0);
    for (int i = 0; i < 73; i++)
      send(i < 37 ? 64'sd5000000 : (i == 40 ? -64'sd2147483648 : -64'sd5000000), 0);
    tone(73, 1, 5000000, 0);
    settle();
    chk("fullscale_amp", amplitude, 2147483647);
    b0 = pv_cnt;
    repeat (300) send(noise(), $urandom_range(0, 1));
    settle();
    chk("noise_no_pv", pv_cnt - b0, 0);
    per = '{183, 82, 73, 0};
    for (int s = 0; s < 6; s++) begin
      w = $urandom_range(0, 3);
      tone(w == 3 ? int'($urandom_range(60, 200)) : per[w], $urandom_range(2, 4), 0, 2);
    end
    tone(82, 3, 0, 1);
    settle();
    chk("d5_note", note_id, 2);
    chk("d5_period", period, 82);
    repeat (MAXP) send(0, 0);
    settle();
    chk("sil_period", period, 0);
    chk("sil_amp", amplitude, 0);
    chk("sil_tone", tone_present, 0);
    chk("sil_note", note_id, 0);
    tone(73, 3, 0, 1);
    aud.audio_in_available = 1'b1;
    aud.left_channel_audio_in = 32'd20000000;
    w = 0;
    do begin @(negedge clk); w++; end while (!aud.read_audio_in && w < 12);
    chk("rf_pop", aud.read_audio_in, 1);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("rf_read_drop", aud.read_audio_in, 0);
    aud.audio_in_available = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rf_tone", tone_present, 0);
    chk("rf_period", period, 0);
    tone(82, 4, 0, 1);
    settle();
    chk("post_rst_note", note_id, 2);
    chk("post_rst_period", period, 82);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
